// File: rtl/training_ctrl_pkg.sv
// Shared definitions for the training epoch sequencer: FSM states, FloPoCo
// exception codes and the +inf constant used to seed the best-error tracker.
package training_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT_RD = 3'd1,
    FWD     = 3'd2,
    EVAL    = 3'd3,
    UPD     = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] EXC_ZERO = 2'b00;
  localparam logic [1:0] EXC_NORM = 2'b01;
  localparam logic [1:0] EXC_INF  = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;

  localparam logic [33:0] FP_POS_INF = 34'h2_7F800000;

endpackage

// File: rtl/fpc_mag_compare.sv
// Combinational less-than on nonnegative FloPoCo values, plus NaN / negative
// flags for operand a.
module fpc_mag_compare
  import training_ctrl_pkg::*;
#(
  parameter int BIT_WIDTH  = 32,
  parameter int EXTRA_BITS = 2,
  parameter int W          = BIT_WIDTH + EXTRA_BITS
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt,
  output logic         a_is_nan,
  output logic         a_is_neg
);

  // Ordering key: zero lowest, normals by exponent/mantissa, inf/NaN saturate.
  function automatic logic [BIT_WIDTH:0] mag_key(input logic [W-1:0] v);
    logic [BIT_WIDTH:0] k;
    case (v[W-1 -: 2])
      EXC_ZERO: k = '0;
      EXC_NORM: k = {2'b01, v[BIT_WIDTH-2:0]};
      default:  k = '1;
    endcase
    return k;
  endfunction

  assign lt       = mag_key(a) < mag_key(b);
  assign a_is_nan = (a[W-1 -: 2] == EXC_NAN);
  assign a_is_neg = (a[W-1 -: 2] == EXC_NORM) && a[BIT_WIDTH-1];

endmodule

// File: rtl/training_sequencer.sv
// Epoch-level controller: initial ROM read, then forward pass / evaluation /
// weight update loop with best-error tracking and convergence / limit / fault exits.
module training_sequencer
  import training_ctrl_pkg::*;
#(
  parameter int BIT_WIDTH        = 32,
  parameter int EXTRA_BITS       = 2,
  parameter int INIT_READ_CYCLES = 4,
  parameter int EPOCH_W          = 16
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            start,
  input  logic                            abort,
  input  logic                            cfg_mode,
  input  logic [EPOCH_W-1:0]              cfg_max_epochs,
  input  logic [BIT_WIDTH+EXTRA_BITS-1:0] cfg_threshold,
  input  logic [BIT_WIDTH+EXTRA_BITS-1:0] cfg_delta,
  input  logic                            ext_stall,
  input  logic                            l2_valid,
  input  logic [BIT_WIDTH+EXTRA_BITS-1:0] l2_error,
  input  logic                            upd_done,
  output logic                            training_mode,
  output logic [BIT_WIDTH+EXTRA_BITS-1:0] delta_val,
  output logic                            local_initial_read_flag,
  output logic                            training_rd,
  output logic                            training_wr,
  output logic                            test_write_buffer_bestweights,
  output logic                            stall,
  output logic                            local_finish,
  output logic [BIT_WIDTH+EXTRA_BITS-1:0] best_error,
  output logic [EPOCH_W-1:0]              epoch_count,
  output logic                            converged,
  output logic                            aborted
);

  localparam int FW    = BIT_WIDTH + EXTRA_BITS;
  localparam int CNT_W = (INIT_READ_CYCLES > 1) ? $clog2(INIT_READ_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INIT_READ_CYCLES - 1);

  state_t            state, nxt;
  logic [CNT_W-1:0]  cnt;
  logic [EPOCH_W-1:0] max_q;
  logic [FW-1:0]     thr_q;
  logic [FW-1:0]     err_q;
  logic              better_q, below_q, bad_q;

  logic lt_best, nan_b, neg_b;
  logic lt_thr, nan_t, neg_t;
  logic bad_now, better_now, start_run;
  logic set_conv, set_abort;
  logic flag_d, rd_d, wr_d, stall_d, finish_d, bw_d;

  fpc_mag_compare #(.BIT_WIDTH(BIT_WIDTH), .EXTRA_BITS(EXTRA_BITS)) u_cmp_best (
    .a        (l2_error),
    .b        (best_error),
    .lt       (lt_best),
    .a_is_nan (nan_b),
    .a_is_neg (neg_b)
  );

  fpc_mag_compare #(.BIT_WIDTH(BIT_WIDTH), .EXTRA_BITS(EXTRA_BITS)) u_cmp_thr (
    .a        (l2_error),
    .b        (thr_q),
    .lt       (lt_thr),
    .a_is_nan (nan_t),
    .a_is_neg (neg_t)
  );

  // Faulty errors never count as an improvement.
  assign bad_now    = nan_b | neg_b | nan_t | neg_t;
  assign better_now = lt_best & ~bad_now;
  assign start_run  = start && (state == IDLE || state == DONE);

  always_comb begin
    nxt       = state;
    set_conv  = 1'b0;
    set_abort = 1'b0;
    case (state)
      IDLE: if (start) nxt = INIT_RD;
      INIT_RD: begin
        // Only cycles on which the flag was actually presented count down.
        if (abort) begin
          nxt       = DONE;
          set_abort = 1'b1;
        end else if (local_initial_read_flag && cnt == '0) begin
          nxt = FWD;
        end
      end
      FWD: begin
        if (abort) begin
          nxt       = DONE;
          set_abort = 1'b1;
        end else if (l2_valid) begin
          nxt = EVAL;
        end
      end
      EVAL: begin
        if (abort || bad_q) begin
          nxt       = DONE;
          set_abort = 1'b1;
        end else if (below_q) begin
          nxt      = DONE;
          set_conv = 1'b1;
        end else if ((epoch_count + EPOCH_W'(1)) == max_q) begin
          nxt = DONE;
        end else begin
          nxt = UPD;
        end
      end
      UPD: begin
        if (abort) begin
          nxt       = DONE;
          set_abort = 1'b1;
        end else if (upd_done) begin
          nxt = FWD;
        end
      end
      DONE: if (start) nxt = INIT_RD;
      default: nxt = IDLE;
    endcase

    flag_d   = (nxt == INIT_RD) && !ext_stall;
    rd_d     = (nxt == FWD) && !ext_stall;
    wr_d     = (nxt == UPD) && !ext_stall;
    stall_d  = (nxt == IDLE) || (nxt == DONE) ||
               (ext_stall && (nxt == INIT_RD || nxt == FWD || nxt == UPD));
    finish_d = (nxt == DONE);
    bw_d     = (state == FWD) && (nxt == EVAL) && better_now;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      local_initial_read_flag       <= 1'b0;
      training_rd                   <= 1'b0;
      training_wr                   <= 1'b0;
      stall                         <= 1'b1;
      local_finish                  <= 1'b0;
      test_write_buffer_bestweights <= 1'b0;
    end else begin
      local_initial_read_flag       <= flag_d;
      training_rd                   <= rd_d;
      training_wr                   <= wr_d;
      stall                         <= stall_d;
      local_finish                  <= finish_d;
      test_write_buffer_bestweights <= bw_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      training_mode <= 1'b0;
      delta_val     <= '0;
      max_q         <= '0;
      thr_q         <= '0;
      cnt           <= '0;
      err_q         <= '0;
      better_q      <= 1'b0;
      below_q       <= 1'b0;
      bad_q         <= 1'b0;
      best_error    <= FP_POS_INF;
      epoch_count   <= '0;
      converged     <= 1'b0;
      aborted       <= 1'b0;
    end else begin
      if (start_run) begin
        training_mode <= cfg_mode;
        delta_val     <= cfg_delta;
        max_q         <= cfg_max_epochs;
        thr_q         <= cfg_threshold;
        cnt           <= CNT_LOAD;
        best_error    <= FP_POS_INF;
        epoch_count   <= '0;
        converged     <= 1'b0;
        aborted       <= 1'b0;
      end
      if (state == INIT_RD && local_initial_read_flag && cnt != '0)
        cnt <= cnt - CNT_W'(1);
      if (state == FWD && l2_valid) begin
        err_q    <= l2_error;
        better_q <= better_now;
        below_q  <= lt_thr;
        bad_q    <= bad_now;
      end
      if (state == EVAL) begin
        epoch_count <= epoch_count + EPOCH_W'(1);
        if (better_q) best_error <= err_q;
      end
      if (nxt == DONE && state != DONE) begin
        converged <= set_conv;
        aborted   <= set_abort;
      end
    end
  end

endmodule

// File: tb/tb_training_sequencer.sv
// Directed plus randomized bench for training_sequencer against an epoch-level
// reference model of best tracking and run termination.
module tb_training_sequencer;

  localparam logic [33:0] INF = 34'h2_7F800000;
  localparam logic [33:0] THR = 34'h1_3A83126F;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        start = 1'b0, abort = 1'b0, cfg_mode = 1'b0;
  logic [15:0] cfg_max_epochs = '0;
  logic [33:0] cfg_threshold = '0, cfg_delta = '0;
  logic        ext_stall = 1'b0, l2_valid = 1'b0, upd_done = 1'b0;
  logic [33:0] l2_error = '0;
  logic        training_mode, local_initial_read_flag, training_rd, training_wr;
  logic        test_write_buffer_bestweights, stall, local_finish, converged, aborted;
  logic [33:0] delta_val, best_error;
  logic [15:0] epoch_count;

  training_sequencer dut (
    .CLK(CLK), .RESET(RESET), .start(start), .abort(abort), .cfg_mode(cfg_mode),
    .cfg_max_epochs(cfg_max_epochs), .cfg_threshold(cfg_threshold), .cfg_delta(cfg_delta),
    .ext_stall(ext_stall), .l2_valid(l2_valid), .l2_error(l2_error), .upd_done(upd_done),
    .training_mode(training_mode), .delta_val(delta_val),
    .local_initial_read_flag(local_initial_read_flag), .training_rd(training_rd),
    .training_wr(training_wr), .test_write_buffer_bestweights(test_write_buffer_bestweights),
    .stall(stall), .local_finish(local_finish), .best_error(best_error),
    .epoch_count(epoch_count), .converged(converged), .aborted(aborted)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state for the current run.
  logic [33:0] m_best, m_thr;
  int          m_count, m_max;
  bit          m_done, m_conv, m_abort;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] ref_key(input logic [33:0] v);
    if (v[33:32] == 2'b00) return 33'd0;
    if (v[33:32] == 2'b01) return {2'b01, v[30:0]};
    return '1;
  endfunction

  function automatic bit ref_bad(input logic [33:0] v);
    return (v[33:32] == 2'b11) || (v[33:32] == 2'b01 && v[31]);
  endfunction

  function automatic logic [33:0] rand_err();
    int c = $urandom_range(0, 19);
    if (c == 0) return 34'h0;
    if (c == 1) return INF;
    if (c == 2) return {2'b11, 32'($urandom)};
    if (c == 3) return {2'b01, 1'b1, 31'($urandom)};
    return {2'b01, 1'b0, 8'($urandom_range(8'h70, 8'h80)), 23'($urandom)};
  endfunction

  task automatic start_run(input bit mode, input int max, input logic [33:0] thr,
                           input logic [33:0] dl);
    cfg_mode = mode; cfg_max_epochs = 16'(max); cfg_threshold = thr; cfg_delta = dl;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_mode = ~mode; cfg_delta = ~dl; cfg_threshold = '0; cfg_max_epochs = '0;
    m_best = INF; m_thr = thr; m_count = 0; m_max = max;
    m_done = 0; m_conv = 0; m_abort = 0;
    check("mode_latch", training_mode, mode);
    check("delta_latch", delta_val, dl);
    check("best_start", best_error, INF);
    check("epoch_start", epoch_count, 0);
    check("flags_start", {converged, aborted, local_finish}, 0);
  endtask

  // Counts flag-high cycles until the forward request appears; optional stall window.
  task automatic run_init(input int st_at, input int st_len);
    int flags = 0, stalled = 0, cyc = 0;
    while (!training_rd && cyc < 60) begin
      if (local_initial_read_flag) flags++;
      if (stall) stalled++;
      ext_stall = (cyc >= st_at && cyc < st_at + st_len);
      tick();
      cyc++;
    end
    ext_stall = 1'b0;
    check("init_to_fwd", training_rd, 1);
    check("init_flag_cycles", flags, 4);
    if (st_len > 0) check("init_stall_cycles", stalled, st_len);
  endtask

  task automatic do_epoch(input logic [33:0] err, input bit vstall);
    int n = 0;
    bit better;
    while (!training_rd && n < 50) begin
      tick();
      n++;
    end
    check("rd_before_valid", training_rd, 1);
    l2_valid = 1'b1; l2_error = err; ext_stall = vstall;
    tick();
    l2_valid = 1'b0; ext_stall = 1'b0; l2_error = 34'($urandom);
    better = !ref_bad(err) && (ref_key(err) < ref_key(m_best));
    if (better) m_best = err;
    m_count++;
    if (ref_bad(err)) begin
      m_done = 1; m_abort = 1;
    end else if (ref_key(err) < ref_key(m_thr)) begin
      m_done = 1; m_conv = 1;
    end else if (m_count == m_max) begin
      m_done = 1;
    end
    check("bestweights_eval", test_write_buffer_bestweights, better);
    check("eval_no_req", {training_rd, training_wr, local_initial_read_flag}, 0);
    tick();
    check("bestweights_after", test_write_buffer_bestweights, 0);
    check("best_error", best_error, m_best);
    check("epoch_count", epoch_count, m_count);
    check("finish", local_finish, m_done);
    check("wr_after_eval", training_wr, !m_done);
    check("converged", converged, m_conv);
    check("aborted", aborted, m_abort);
  endtask

  task automatic do_upd(input bit noise);
    int k = $urandom_range(0, 3);
    bit ps;
    for (int i = 0; i < k; i++) begin
      ext_stall = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      l2_valid  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      check("wr_hold", training_wr, !ext_stall);
      check("stall_upd", stall, ext_stall);
    end
    l2_valid = 1'b0;
    ps = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    ext_stall = ps; upd_done = 1'b1;
    tick();
    upd_done = 1'b0; ext_stall = 1'b0;
    check("rd_after_upd", training_rd, !ps);
    check("wr_after_upd", training_wr, 0);
    check("epoch_in_upd", epoch_count, m_count);
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    m_done = 1; m_abort = 1;
    check("abort_finish", local_finish, 1);
    check("abort_flag", aborted, 1);
    check("abort_reqs", {training_rd, training_wr}, 0);
    check("abort_stall", stall, 1);
    check("abort_best", best_error, m_best);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick(); tick();
    check("rst_stall", stall, 1);
    check("rst_best", best_error, INF);
    check("rst_reqs", {local_initial_read_flag, training_rd, training_wr,
                       test_write_buffer_bestweights, local_finish}, 0);
    check("rst_status", {converged, aborted, training_mode, epoch_count, delta_val}, 0);
    RESET = 1'b1;
    tick();

    // Init read then reset mid forward pass
    start_run(1'b0, 5, THR, 34'h1_3C23D70A);
    run_init(0, 0);
    RESET = 1'b0;
    #1;
    check("midrst_reqs", {local_initial_read_flag, training_rd, training_wr}, 0);
    check("midrst_stall", stall, 1);
    tick();
    RESET = 1'b1;
    tick();
    check("midrst_no_finish", local_finish, 0);

    // Best tracking, ignored start while active, abort in UPD, abort in DONE
    start_run(1'b1, 10, THR, 34'h1_3D000000);
    run_init(0, 0);
    do_epoch(34'h1_3F000000, 1'b0); do_upd(1'b0);
    do_epoch(34'h1_3E800000, 1'b0); do_upd(1'b0);
    do_epoch(34'h1_3F000000, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ignored_wr", training_wr, 1);
    check("start_ignored_epoch", epoch_count, 3);
    do_abort();
    check("best_tracked", best_error, 34'h1_3E800000);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("done_abort_ignored", {local_finish, aborted, stall}, 3'b111);

    // Convergence at epoch 0
    start_run(1'b0, 10, THR, 34'h1_3F800000);
    run_init(0, 0);
    do_epoch(34'h1_3A03126F, 1'b0);

    // Epoch limit
    start_run(1'b0, 3, THR, 34'h1_3F800000);
    run_init(0, 0);
    do_epoch(34'h1_3DCCCCCD, 1'b0); do_upd(1'b0);
    do_epoch(34'h1_3DCCCCCD, 1'b0); do_upd(1'b0);
    do_epoch(34'h1_3DCCCCCD, 1'b0);

    // NaN error
    start_run(1'b1, 10, THR, 34'h1_3F800000);
    run_init(0, 0);
    do_epoch({2'b11, 32'h7FC00000}, 1'b0);

    // Stall during init and l2_valid together with stall
    start_run(1'b0, 10, THR, 34'h1_3F800000);
    run_init(1, 5);
    do_epoch(34'h1_3F000000, 1'b1);
    do_abort();

    // Randomized runs
    for (int r = 0; r < 12; r++) begin
      start_run(1'($urandom_range(0, 1)), $urandom_range(1, 6),
                {2'b01, 1'b0, 8'($urandom_range(8'h74, 8'h7C)), 23'($urandom)},
                34'($urandom));
      run_init($urandom_range(0, 3), $urandom_range(0, 4));
      while (!m_done) begin
        do_epoch(rand_err(), 1'($urandom_range(0, 1)));
        if (!m_done) begin
          if ($urandom_range(0, 9) == 0) do_abort();
          else do_upd(1'b1);
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/training_sequencer.md
Name: training_sequencer

Overview:
- Epoch-level controller for the training datapath (test_block): drives local_initial_read_flag, training_rd, training_wr, test_write_buffer_bestweights, stall and local_finish.
- Runs the initial ROM weight read, then loops forward pass → error evaluation → weight update.
- Tracks the best l2_error. Stops on convergence, epoch limit, NaN/negative error or abort.
- Sits between the host/config register block and test_block.

Parameters:
- BIT_WIDTH, 32, IEEE-754 single payload width.
- EXTRA_BITS, 2, FloPoCo exception bits prepended (00 zero, 01 normal, 10 inf, 11 NaN).
- INIT_READ_CYCLES, 4, cycles local_initial_read_flag is held.
- EPOCH_W, 16, epoch counter width.

Ports:
- CLK, in, 1, clock.
- RESET, in, 1, asynchronous active-low reset.
- start, in, 1, pulse; begins a run from IDLE or DONE.
- abort, in, 1, pulse; ends the run from any active state.
- cfg_mode, in, 1, 1 = Manhattan, 0 = Adam; latched on start.
- cfg_max_epochs, in, EPOCH_W, epoch limit (≥1); latched on start.
- cfg_threshold, in, 34, convergence error; latched on start.
- cfg_delta, in, 34, learning step; latched on start.
- ext_stall, in, 1, downstream back-pressure.
- l2_valid, in, 1, pulse; l2_error valid this cycle.
- l2_error, in, 34, epoch error from datapath.
- upd_done, in, 1, pulse; weight update finished.
- training_mode, out, 1, latched cfg_mode.
- delta_val, out, 34, latched cfg_delta.
- local_initial_read_flag, out, 1, ROM weight load.
- training_rd, out, 1, forward-pass request.
- training_wr, out, 1, weight-update request.
- test_write_buffer_bestweights, out, 1, snapshot weights to best buffer.
- stall, out, 1, datapath hold.
- local_finish, out, 1, run complete.
- best_error, out, 34, lowest error this run.
- epoch_count, out, EPOCH_W, completed evaluations.
- converged, out, 1, finished by threshold.
- aborted, out, 1, finished by abort, NaN or negative error.

Behaviour:
- All outputs are registered.
- Reset values: every output 0, except stall = 1 and best_error = 34'h2_7F800000 (+inf). State = IDLE.
- Reset mid-run returns to IDLE immediately; no finish pulse is generated.

States:
- IDLE: stall = 1. On start: latch cfg, clear epoch_count/converged/aborted, set best_error = +inf, load cnt = INIT_READ_CYCLES-1, go to INIT_RD.
- INIT_RD: local_initial_read_flag = 1, stall = 0. Decrement cnt each non-stalled cycle. At cnt == 0 go to FWD. Flag is high exactly INIT_READ_CYCLES unstalled cycles.
- FWD: training_rd = 1 until l2_valid. Capture l2_error into err_q; compute better = err_q < best_error. Go to EVAL.
- EVAL: exactly 1 cycle, all requests low.
  - If better: test_write_buffer_bestweights = 1 this cycle and best_error ← err_q.
  - epoch_count increments.
  - Exit priority:
    1. err_q NaN, or normal with sign = 1 → DONE, aborted = 1.
    2. err_q < cfg_threshold → DONE, converged = 1.
    3. epoch_count+1 == cfg_max_epochs → DONE.
    4. Otherwise → UPD.
- UPD: training_wr = 1 until upd_done, then FWD.
- DONE: local_finish = 1 and stall = 1, held. converged/aborted/best_error/epoch_count are held. start restarts the run as from IDLE.

Stall and event rules:
- ext_stall in INIT_RD/FWD/UPD: state and cnt freeze, training_rd/training_wr/flag drop, stall = 1.
- l2_valid or upd_done arriving together with ext_stall is still captured; capture wins over stall.
- abort in INIT_RD/FWD/EVAL/UPD → DONE, aborted = 1. abort in IDLE or DONE is ignored.
- start while active is ignored.
- l2_valid outside FWD and upd_done outside UPD are ignored.

Compare rule (unsigned, nonnegative only):
- key = 0 for exc 00.
- key = {2'b01, bits[30:0]} for exc 01.
- key = all-ones for exc 10.
- a < b iff key(a) < key(b).
- An error equal to best is not better.

Decomposition:
- training_ctrl_pkg: state enum (IDLE, INIT_RD, FWD, EVAL, UPD, DONE); exception codes EXC_ZERO/NORM/INF/NAN; FP_POS_INF constant.
- Sub-module fpc_mag_compare: combinational 34-bit FloPoCo less-than plus is_nan/is_neg flags. Instantiated twice, once vs best_error and once vs cfg_threshold.

Test Plan:
1. Reset/init: RESET low 2 cycles, then start with INIT_READ_CYCLES = 4 → local_initial_read_flag high exactly 4 cycles, then training_rd = 1. RESET low mid-FWD → all requests 0, stall = 1 the same cycle.
2. Best tracking: threshold 0x1_3A83126F (0.001), errors 0x1_3F000000, 0x1_3E800000, 0x1_3F000000 → bestweights pulses in epochs 0 and 1 only; best_error = 0x1_3E800000.
3. Convergence: error 0x1_3A03126F (0.0005) at epoch 0 → no training_wr; local_finish = 1, converged = 1, epoch_count = 1.
4. Epoch limit: cfg_max_epochs = 3, all errors 0x1_3DCCCCCD (0.1) → three EVALs, two UPDs, local_finish with converged = 0; one bestweights pulse only.
5. Fault/abort: error exc = 11 → DONE, aborted = 1. Separately, abort during UPD → DONE next cycle, training_wr = 0.
6. Stall: ext_stall high 5 cycles in INIT_RD → flag low during the stall, still 4 total high cycles. l2_valid coincident with ext_stall → error captured, EVAL follows.
